tdm_slot_arbiter: RTL and testbench
===================================

# tdm_slot_arbiter

Time-division bus arbiter that sits directly downstream of the team's one-hot ring counter and consumes its N-bit rotating token as the slot schedule. Each requester may win the shared resource only while the ring-counter token points at its slot. Once granted, it holds the grant until it releases or a timeout expires. The arbiter also monitors the incoming token and flags any cycle in which it is not one-hot.

## Interface
- N, 4: number of channels and token width; N >= 2.
- TMO, 15: maximum grant length in cycles, 2..255.
- IDXW, $clog2(N): width of the owner index.
- clock  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-low.
- slot  input  N  one-hot token from the ring counter; bit i means slot i is current.
- req  input  N  request pulses, one bit per channel; sampled every edge.
- rel  input  1  release pulse from the current owner; ignored unless in GRANT.
- gnt  output  N  one-hot grant, or zero.
- owner  output  IDXW  index of the last granted channel.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout.
- slot_err  output  1  sticky flag: slot was seen not one-hot.
- gnt_count  output  8  number of grants issued; wraps 255 -> 0.

## Operation
- Internal state:
  - pending[N-1:0] request latches.
  - FSM with states IDLE, GRANT, GAP.
  - Hold counter cnt, 8 bits.
- pending update, every edge with rst=1:
  - req[i]=1 sets pending[i].
  - Issuing a grant to channel i clears pending[i].
  - If both happen to the same bit in the same edge, set wins and pending[i] stays 1.
- IDLE:
  - Grant when slot is exactly one-hot at bit i, pending[i]=1 (registered value), and slot_err=0.
  - Grant actions: gnt <= one-hot i, owner <= i, busy <= 1, cnt <= 0, gnt_count <= gnt_count+1, next state GRANT.
  - Otherwise remain in IDLE with gnt=0.
- GRANT:
  - slot is ignored; the ring keeps rotating.
  - If rel=1: gnt <= 0, busy <= 0, next state GAP.
  - Else if cnt == TMO-1: gnt <= 0, busy <= 0, timeout <= 1, next state GAP.
  - Else cnt <= cnt+1.
  - If rel arrives on the timeout edge, it is a normal release and timeout stays 0.
- GAP:
  - Exactly one cycle, then IDLE.
  - timeout is cleared on leaving GAP, so it is high for exactly one cycle.
  - No grant can be issued from GAP.
- slot monitor:
  - At any edge with rst=1 where popcount(slot) != 1 (zero, or more than one bit set), slot_err <= 1.
  - slot_err is sticky until reset.
  - While slot_err=1, no new grants are issued; a grant already in progress completes normally.
- Requests for the current owner during GRANT are latched in pending and are served at that channel's next slot after GAP.
- Reset (rst=0 at an edge), valid from any state including mid-grant:
  - State IDLE.
  - gnt=0, owner=0, busy=0, timeout=0, slot_err=0, pending=0, gnt_count=0, cnt=0.
  - req and slot are ignored while rst=0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Minimum latency: req[i] sampled at edge E0, slot=bit i at edge E1 > E0, gives gnt[i] high in the cycle after E1.
  - Best case is req to gnt in 2 edges.
  - Worst case is N+1 edges plus any grant in progress, plus 1 GAP cycle.
- Grant length: gnt is high for k cycles when rel is sampled at the k-th edge after the grant edge.
  - With no release, gnt is high for exactly TMO cycles.
- Minimum spacing between two grants is 1 idle cycle (GAP) plus the wait for a matching slot.
- gnt_count increments on the same edge that gnt rises.

## Test plan
- Reset with slot=0001 and req=0000 held for 3 cycles, then release rst -> all outputs 0, no grant for 4 further cycles.
- One-cycle pulse req=0100, slot rotating 0001 -> 0010 -> 0100 -> gnt=0100, owner=2, busy=1 in the cycle after slot=0100 is sampled. rel pulsed on the 3rd grant cycle -> gnt=0 for one GAP cycle, gnt_count=1.
- req[1] granted with rel never asserted (TMO=15) -> gnt=0010 for exactly 15 cycles, then timeout=1 for one cycle. Separately, rel on the timeout edge -> timeout stays 0.
- req=1111 pulsed once -> grants issued in token order 0001, 0010, 0100, 1000 with gnt_count reaching 4. Pulsing req[owner] during a grant -> that channel is re-granted at its next slot.
- slot=0110 for one cycle while pending=0001 -> slot_err=1 and stays 1, no grant issued, until rst=0 clears it.
- rst=0 in the middle of a grant -> on the next cycle gnt=0, busy=0, pending=0, gnt_count=0. After rst returns to 1, no grant is issued until a new req.

Source files
------------

// File: rtl/tdm_slot_arbiter.sv
// Time-division bus arbiter: grants channel i only while the ring-counter token
// selects slot i, holds the grant until release or timeout, and flags bad tokens.
module tdm_slot_arbiter #(
   parameter int N    = 4,
   parameter int TMO  = 15,
   parameter int IDXW = $clog2(N)
) (
   input  logic            clock,
   input  logic            rst,
   input  logic [N-1:0]    slot,
   input  logic [N-1:0]    req,
   input  logic            rel,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] owner,
   output logic            busy,
   output logic            timeout,
   output logic            slot_err,
   output logic [7:0]      gnt_count
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t          state, state_n;
   logic [N-1:0]    pending, pending_n, clr;
   logic [N-1:0]    gnt_n;
   logic [IDXW-1:0] owner_n, idx;
   logic            busy_n, timeout_n, slot_err_n, onehot;
   logic [7:0]      cnt, cnt_n, gnt_count_n;

   always_ff @(posedge clock) begin
      if (!rst) begin
         state     <= IDLE;
         pending   <= '0;
         gnt       <= '0;
         owner     <= '0;
         busy      <= 1'b0;
         timeout   <= 1'b0;
         slot_err  <= 1'b0;
         cnt       <= '0;
         gnt_count <= '0;
      end else begin
         state     <= state_n;
         pending   <= pending_n;
         gnt       <= gnt_n;
         owner     <= owner_n;
         busy      <= busy_n;
         timeout   <= timeout_n;
         slot_err  <= slot_err_n;
         cnt       <= cnt_n;
         gnt_count <= gnt_count_n;
      end
   end

   always_comb begin
      onehot = ($countones(slot) == 1);
      idx    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (slot[i]) idx = IDXW'(i);
      end
   end

   always_comb begin
      state_n     = state;
      gnt_n       = gnt;
      owner_n     = owner;
      busy_n      = busy;
      timeout_n   = timeout;
      cnt_n       = cnt;
      gnt_count_n = gnt_count;
      clr         = '0;
      slot_err_n  = slot_err | ~onehot;

      case (state)
         IDLE: begin
            gnt_n = '0;
            // Decision uses the registered slot_err, so the edge that first sees a bad token cannot grant either.
            if (onehot && pending[idx] && !slot_err) begin
               gnt_n[idx]  = 1'b1;
               owner_n     = idx;
               busy_n      = 1'b1;
               cnt_n       = '0;
               gnt_count_n = gnt_count + 8'd1;
               clr[idx]    = 1'b1;
               state_n     = GRANT;
            end
         end
         GRANT: begin
            if (rel) begin
               gnt_n   = '0;
               busy_n  = 1'b0;
               state_n = GAP;
            end else if (cnt == 8'(TMO - 1)) begin
               gnt_n     = '0;
               busy_n    = 1'b0;
               timeout_n = 1'b1;
               state_n   = GAP;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         GAP: begin
            gnt_n     = '0;
            timeout_n = 1'b0;
            state_n   = IDLE;
         end
         default: begin
            gnt_n   = '0;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
      endcase

      // A new request on the same edge as its grant survives the clear.
      pending_n = (pending & ~clr) | req;
   end

endmodule

// File: tb/tb_tdm_slot_arbiter.sv
// Directed bench for tdm_slot_arbiter: steps the token ring by hand and checks
// grants, release/timeout timing, slot monitor and reset against fixed values.
module tb_tdm_slot_arbiter;

   localparam int N    = 4;
   localparam int TMO  = 15;
   localparam int IDXW = 2;

   logic            clock = 1'b0;
   logic            rst;
   logic [N-1:0]    slot, req;
   logic            rel;
   logic [N-1:0]    gnt;
   logic [IDXW-1:0] owner;
   logic            busy, timeout, slot_err;
   logic [7:0]      gnt_count;

   int vectors     = 0;
   int miscompares = 0;
   logic [3:0] ring;

   always #5 clock = ~clock;

   tdm_slot_arbiter #(.N(N), .TMO(TMO), .IDXW(IDXW)) dut (
      .clock     (clock),
      .rst       (rst),
      .slot      (slot),
      .req       (req),
      .rel       (rel),
      .gnt       (gnt),
      .owner     (owner),
      .busy      (busy),
      .timeout   (timeout),
      .slot_err  (slot_err),
      .gnt_count (gnt_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic [3:0] s, input logic [3:0] r, input logic rl);
      slot = s;
      req  = r;
      rel  = rl;
      @(posedge clock);
      #1;
   endtask

   task automatic tickr(input logic [3:0] r, input logic rl);
      tick(ring, r, rl);
      ring = {ring[2:0], ring[3]};
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (3) tick(4'b0001, 4'b0000, 1'b0);
      rst = 1'b1;
   endtask

   initial begin
      rst  = 1'b0;
      slot = 4'b0001;
      req  = 4'b0000;
      rel  = 1'b0;

      // reset state
      repeat (3) tick(4'b0001, 4'b0000, 1'b0);
      chk("rst_gnt",      32'(gnt),       32'h0);
      chk("rst_owner",    32'(owner),     32'h0);
      chk("rst_busy",     32'(busy),      32'h0);
      chk("rst_timeout",  32'(timeout),   32'h0);
      chk("rst_slot_err", 32'(slot_err),  32'h0);
      chk("rst_count",    32'(gnt_count), 32'h0);
      rst  = 1'b1;
      ring = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         tickr(4'b0000, 1'b0);
         chk("idle_nogrant", 32'(gnt), 32'h0);
      end

      // single request, released on 3rd grant cycle
      ring = 4'b0001;
      tickr(4'b0100, 1'b0);
      chk("t2_wait0", 32'(gnt), 32'h0);
      tickr(4'b0000, 1'b0);
      chk("t2_wait1", 32'(gnt), 32'h0);
      tickr(4'b0000, 1'b0);
      chk("t2_gnt",   32'(gnt),       32'h4);
      chk("t2_owner", 32'(owner),     32'h2);
      chk("t2_busy",  32'(busy),      32'h1);
      chk("t2_count", 32'(gnt_count), 32'h1);
      tickr(4'b0000, 1'b0);
      chk("t2_hold1", 32'(gnt), 32'h4);
      tickr(4'b0000, 1'b0);
      chk("t2_hold2", 32'(gnt), 32'h4);
      tickr(4'b0000, 1'b1);
      chk("t2_rel_gnt",     32'(gnt),       32'h0);
      chk("t2_rel_busy",    32'(busy),      32'h0);
      chk("t2_rel_timeout", 32'(timeout),   32'h0);
      chk("t2_rel_count",   32'(gnt_count), 32'h1);
      chk("t2_rel_owner",   32'(owner),     32'h2);
      tickr(4'b0000, 1'b0);
      chk("t2_gap_gnt", 32'(gnt), 32'h0);

      // timeout after exactly TMO grant cycles
      ring = 4'b0001;
      tickr(4'b0010, 1'b0);
      tickr(4'b0000, 1'b0);
      chk("t3_gnt",   32'(gnt),       32'h2);
      chk("t3_count", 32'(gnt_count), 32'h2);
      for (int i = 0; i < 14; i++) begin
         tickr(4'b0000, 1'b0);
         chk("t3_hold", 32'(gnt), 32'h2);
         chk("t3_hold_tmo", 32'(timeout), 32'h0);
      end
      tickr(4'b0000, 1'b0);
      chk("t3_tmo_gnt",  32'(gnt),     32'h0);
      chk("t3_tmo_flag", 32'(timeout), 32'h1);
      chk("t3_tmo_busy", 32'(busy),    32'h0);
      tickr(4'b0000, 1'b0);
      chk("t3_tmo_clear", 32'(timeout), 32'h0);

      // release on the timeout edge is a normal release
      ring = 4'b0001;
      tickr(4'b0010, 1'b0);
      tickr(4'b0000, 1'b0);
      chk("t3b_gnt",   32'(gnt),       32'h2);
      chk("t3b_count", 32'(gnt_count), 32'h3);
      repeat (14) tickr(4'b0000, 1'b0);
      tickr(4'b0000, 1'b1);
      chk("t3b_gnt_off", 32'(gnt),     32'h0);
      chk("t3b_no_tmo",  32'(timeout), 32'h0);
      chk("t3b_busy",    32'(busy),    32'h0);
      tickr(4'b0000, 1'b0);
      chk("t3b_no_tmo2", 32'(timeout), 32'h0);

      // all four request at once: token order, then re-request by owner
      do_reset();
      ring = 4'b1000;
      tickr(4'b1111, 1'b0);
      chk("t4_nogrant", 32'(gnt), 32'h0);
      for (int ch = 0; ch < 4; ch++) begin
         tickr(4'b0000, 1'b0);
         chk("t4_gnt",   32'(gnt),       32'(1 << ch));
         chk("t4_count", 32'(gnt_count), 32'(ch + 1));
         tickr((ch == 3) ? 4'b1000 : 4'b0000, 1'b0);
         tickr(4'b0000, 1'b0);
         tickr(4'b0000, 1'b1);
         chk("t4_rel", 32'(gnt), 32'h0);
         tickr(4'b0000, 1'b0);
         chk("t4_gap", 32'(gnt), 32'h0);
      end
      repeat (2) tickr(4'b0000, 1'b0);
      tickr(4'b0000, 1'b0);
      chk("t4_wait_slot", 32'(gnt), 32'h0);
      tickr(4'b0000, 1'b0);
      chk("t4_regrant",       32'(gnt),       32'h8);
      chk("t4_regrant_count", 32'(gnt_count), 32'h5);
      tickr(4'b0000, 1'b1);
      tickr(4'b0000, 1'b0);

      // slot monitor
      tick(4'b0100, 4'b0001, 1'b0);
      chk("t5_err_before", 32'(slot_err), 32'h0);
      tick(4'b0110, 4'b0000, 1'b0);
      chk("t5_err_set", 32'(slot_err), 32'h1);
      chk("t5_gnt0",    32'(gnt),      32'h0);
      tick(4'b1000, 4'b0000, 1'b0);
      tick(4'b0001, 4'b0000, 1'b0);
      chk("t5_blocked", 32'(gnt),      32'h0);
      chk("t5_sticky",  32'(slot_err), 32'h1);
      tick(4'b0010, 4'b0000, 1'b0);
      chk("t5_sticky2", 32'(slot_err), 32'h1);
      rst = 1'b0;
      tick(4'b0001, 4'b0000, 1'b0);
      chk("t5_err_rst", 32'(slot_err), 32'h0);
      rst = 1'b1;
      tick(4'b0001, 4'b0000, 1'b0);
      chk("t5_pend_cleared", 32'(gnt), 32'h0);
      tick(4'b0000, 4'b0000, 1'b0);
      chk("t5_zero_slot", 32'(slot_err), 32'h1);
      do_reset();

      // reset in the middle of a grant
      tick(4'b1000, 4'b0001, 1'b0);
      tick(4'b0001, 4'b0000, 1'b0);
      chk("t6_gnt",   32'(gnt),       32'h1);
      chk("t6_count", 32'(gnt_count), 32'h1);
      tick(4'b0010, 4'b0010, 1'b0);
      chk("t6_hold", 32'(gnt), 32'h1);
      rst = 1'b0;
      tick(4'b0100, 4'b0100, 1'b0);
      chk("t6_rst_gnt",   32'(gnt),       32'h0);
      chk("t6_rst_busy",  32'(busy),      32'h0);
      chk("t6_rst_count", 32'(gnt_count), 32'h0);
      chk("t6_rst_owner", 32'(owner),     32'h0);
      rst  = 1'b1;
      ring = 4'b1000;
      for (int i = 0; i < 8; i++) begin
         tickr(4'b0000, 1'b0);
         chk("t6_no_grant", 32'(gnt), 32'h0);
      end
      tickr(4'b0001, 1'b0);
      tickr(4'b0000, 1'b0);
      chk("t6_new_gnt",   32'(gnt),       32'h1);
      chk("t6_new_count", 32'(gnt_count), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
